mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache (port 0, read-only refills) and the D-cache (port 1, refills and dirty-line writebacks).
- Each granted request runs as one LINE_WORDS-beat line burst.
- Arbitration is round-robin when both ports request, and the block sequences beat addresses.
- A per-beat timeout drives an error exit; the block sits between the cache controllers and the memory model/bus.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width (byte stride per beat = DATA_W/8).
- LINE_WORDS, 8, beats per burst (power of two, >=2).
- TIMEOUT, 255, max cycles waiting on mem_ack for one beat.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-port request; held with addr/we stable until done.
- we1  in  1  port-1 write (writeback) flag; port 0 always reads.
- addr0, addr1  in  ADDR_W  line address; offset bits ignored (forced 0).
- wdata1  in  DATA_W  port-1 write word for current beat_idx.
- grant  out  2  one-hot owner of the memory port.
- beat_idx  out  $clog2(LINE_WORDS)  current beat number.
- rdata  out  DATA_W  = mem_rdata (combinational pass-through).
- rvalid  out  2  per-port read beat valid.
- wready  out  1  port-1 write beat accepted.
- done  out  2  one-cycle burst-complete pulse per port.
- error  out  1  one-cycle timeout pulse, coincident with done.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  beat address.
- mem_wdata  out  DATA_W  = wdata1.
- mem_rdata  in  DATA_W  read data.
- mem_ack  in  1  beat complete (read data valid / write data taken).

Behaviour:
- Reset: state IDLE; all outputs 0; beat and timeout counters 0; rr pointer favours port 0. rst mid-burst aborts immediately, no done pulse; memory must tolerate mem_req dropping.
- States: IDLE, XFER, DONE, ERROR.
- IDLE:
  - req==00: stay in IDLE.
  - One port requesting: that port wins.
  - Both requesting: rr pointer decides; pointer flips to the other port whenever a grant is issued.
  - Registered next cycle: state XFER, grant one-hot, latch owner/we/base (= addr with low $clog2(LINE_WORDS*DATA_W/8) bits cleared), beat=0.
- XFER:
  - Outputs: mem_req=1, mem_we = owner==1 && we1 latched, mem_addr = base + beat*(DATA_W/8).
  - rvalid[owner] = mem_ack & !mem_we; wready = mem_ack & mem_we (combinational).
  - On mem_ack: beat++ and timeout counter cleared. When the ack is on beat LINE_WORDS-1, go to DONE.
  - With no ack: timeout counter++. When it reaches TIMEOUT, go to ERROR.
- DONE: mem_req=0, grant=0, done[owner]=1 for one cycle; next state IDLE.
- ERROR: mem_req=0, grant=0, done[owner]=1, error=1 for one cycle; next state IDLE.
- Back-to-back: re-arbitration happens only in IDLE, so the minimum gap between bursts is 2 cycles (DONE, IDLE).
- Fixed-ack burst latency: req seen at cycle t, first beat at t+1, done at t+1+LINE_WORDS.
- req deasserted mid-burst: ignored; burst completes and done still pulses.
- req changes on the non-owner port during a burst: no effect until IDLE.
- mem_ack outside XFER: ignored.
- beat counter wraps to 0 on entering DONE.
- Address arithmetic is modulo 2^ADDR_W.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, XFER, DONE, ERROR), port index constants PORT_I=0 and PORT_D=1, localparams BEAT_W and OFFSET_W derived from parameters.
- One sub-module rr_arb2: 2-requester round-robin with registered priority pointer, update-on-grant input, one-hot grant output.

Test Plan:
- Port-0 read, addr0=0x1004, mem_ack every cycle:
  - grant=01.
  - mem_addr 0x1000, 0x1004 … 0x101C.
  - 8 rvalid[0] pulses; done[0] 9 cycles after req; error=0.
- Both req in same cycle from reset:
  - Port 0 served first, then port 1, with a 2-cycle gap.
  - Both held again afterwards: order is 0, 1, 0, 1.
- Port-1 writeback, we1=1, addr1=0x2000, ack every 3rd cycle:
  - mem_we=1; 8 wready pulses; beat_idx steps 0..7.
  - mem_addr advances only on ack; done[1] after 24 XFER cycles.
- Timeout with TIMEOUT=4, no ack after beat 2:
  - Exactly 4 stall cycles, then error=1 and done[x]=1 for one cycle.
  - mem_req drops; IDLE on the following cycle.
- rst asserted at beat 5 of a read:
  - Next cycle all outputs 0, no done pulse.
  - A new port-1 req is granted 1 cycle after rst deasserts.
- req[0] dropped at beat 3:
  - Burst still completes 8 beats and done[0] pulses; port 1 waiting is granted next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the main-memory arbiter.
// Widths that depend on module parameters are computed through the helper functions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE,
    ERROR
  } arb_state_e;

  localparam int unsigned PORT_I = 0;
  localparam int unsigned PORT_D = 1;

  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned BEAT_W         = $clog2(LINE_WORDS_DEF);
  localparam int unsigned OFFSET_W       = $clog2(LINE_WORDS_DEF * DATA_W_DEF / 8);

  function automatic int unsigned beat_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned offset_bits(input int unsigned line_words,
                                              input int unsigned data_w);
    return $clog2(line_words * data_w / 8);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
// When both ports request, the pointer picks the winner; it moves past the winner on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;  // 0: port 0 favoured, 1: port 1 favoured

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
    ptr_d = ptr_q;
    if (update && (|grant)) ptr_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between the I-cache (port 0) and D-cache (port 1),
// running each grant as one line burst with a per-beat ack timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req,
  input  logic                          we1,
  input  logic [ADDR_W-1:0]             addr0,
  input  logic [ADDR_W-1:0]             addr1,
  input  logic [DATA_W-1:0]             wdata1,
  output logic [1:0]                    grant,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
  output logic [DATA_W-1:0]             rdata,
  output logic [1:0]                    rvalid,
  output logic                          wready,
  output logic [1:0]                    done,
  output logic                          error,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack
);

  localparam int unsigned BW     = beat_bits(LINE_WORDS);
  localparam int unsigned OW     = offset_bits(LINE_WORDS, DATA_W);
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam int unsigned STRIDE = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OW;

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic [1:0]        arb_grant;
  logic              arb_update;
  logic [1:0]        owner_oh;
  logic              in_xfer;

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .grant  (arb_grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    base_d     = base_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    arb_update = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          arb_update = 1'b1;
          state_d    = XFER;
          owner_d    = arb_grant[PORT_D];
          we_d       = arb_grant[PORT_D] & we1;
          base_d     = (arb_grant[PORT_D] ? addr1 : addr0) & BASE_MASK;
          beat_d     = '0;
          tmo_d      = '0;
        end
      end
      XFER: begin
        if (mem_ack) begin
          tmo_d  = '0;
          beat_d = beat_q + BW'(1);  // last beat wraps the counter back to 0
          if (beat_q == BW'(LINE_WORDS - 1)) state_d = DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ERROR;
          beat_d  = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE, ERROR: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    owner_oh  = owner_q ? 2'b10 : 2'b01;
    in_xfer   = (state_q == XFER);
    grant     = in_xfer ? owner_oh : '0;
    mem_req   = in_xfer;
    mem_we    = in_xfer & we_q;
    mem_addr  = in_xfer ? (base_q + ADDR_W'(beat_q) * ADDR_W'(STRIDE)) : '0;
    rvalid    = (in_xfer & mem_ack & ~we_q) ? owner_oh : '0;
    wready    = in_xfer & mem_ack & we_q;
    done      = ((state_q == DONE) || (state_q == ERROR)) ? owner_oh : '0;
    error     = (state_q == ERROR);
    beat_idx  = beat_q;
    rdata     = mem_rdata;
    mem_wdata = wdata1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bursts against a transaction-level model of the arbiter:
// round-robin order, beat addresses, per-beat handshakes, completion and timeout.
module tb_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LW     = 8;
  localparam int TO     = 4;
  localparam int STRIDE = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic          we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata1;
  logic [1:0]    grant;
  logic [2:0]    beat_idx;
  logic [DW-1:0] rdata;
  logic [1:0]    rvalid;
  logic          wready;
  logic [1:0]    done;
  logic          error;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int checks = 0;
  int errors = 0;
  int rr_pref = 0;  // port that wins when both request

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LINE_WORDS (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .grant     (grant),
    .beat_idx  (beat_idx),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .wready    (wready),
    .done      (done),
    .error     (error),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return rr_pref;
    return r[1] ? 1 : 0;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"},    64'(grant),    64'(0));
    chk({tag, "_rvalid"},   64'(rvalid),   64'(0));
    chk({tag, "_wready"},   64'(wready),   64'(0));
    chk({tag, "_done"},     64'(done),     64'(0));
    chk({tag, "_error"},    64'(error),    64'(0));
    chk({tag, "_mem_req"},  64'(mem_req),  64'(0));
    chk({tag, "_mem_we"},   64'(mem_we),   64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_beat_idx"}, 64'(beat_idx), 64'(0));
  endtask

  // Entry: DUT in IDLE with req already driven. Exit: DUT in IDLE (or just reset).
  task automatic run_burst(input string tag, input int port, input int period,
                           input int noack_from, input int drop_at, input int rst_at,
                           input bit keep_req);
    logic [AW-1:0] base;
    logic [1:0]    oh;
    bit            wr, ack, exp_err;
    int            beat, stalls, cyc;
    base    = (port == 1 ? addr1 : addr0) & ~AW'(LW * STRIDE - 1);
    oh      = (port == 1) ? 2'b10 : 2'b01;
    wr      = (port == 1) && we1;
    beat    = 0;
    stalls  = 0;
    cyc     = 0;
    exp_err = 1'b0;
    step();
    while (beat < LW) begin
      if (beat == rst_at) begin
        chk({tag, "_rst_beat"}, 64'(beat_idx), 64'(rst_at));
        rst = 1'b1; req = 2'b00; mem_ack = 1'b0;
        step();
        check_quiet({tag, "_rst"});
        rst = 1'b0;
        rr_pref = 0;
        return;
      end
      if (beat == drop_at) req[port] = 1'b0;
      wdata1    = $urandom;
      mem_rdata = $urandom;
      if (noack_from >= 0 && beat >= noack_from) ack = 1'b0;
      else if (period > 0)                       ack = (cyc % period) == period - 1;
      else                                       ack = (stalls == TO - 1) || ($urandom_range(0, 1) == 1);
      mem_ack = ack;
      #1;
      chk({tag, "_grant"},     64'(grant),     64'(oh));
      chk({tag, "_mem_req"},   64'(mem_req),   64'(1));
      chk({tag, "_mem_we"},    64'(mem_we),    64'(wr));
      chk({tag, "_beat_idx"},  64'(beat_idx),  64'(beat));
      chk({tag, "_mem_addr"},  64'(mem_addr),  64'(AW'(base + AW'(beat * STRIDE))));
      chk({tag, "_rvalid"},    64'(rvalid),    64'((ack && !wr) ? oh : 2'b00));
      chk({tag, "_wready"},    64'(wready),    64'(ack && wr));
      chk({tag, "_rdata"},     64'(rdata),     64'(mem_rdata));
      chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(wdata1));
      chk({tag, "_no_done"},   64'(done),      64'(0));
      cyc++;
      if (ack) begin beat++; stalls = 0; end
      else stalls++;
      step();
      mem_ack = 1'b0;
      if (stalls == TO) begin
        exp_err = 1'b1;
        break;
      end
    end
    // completion cycle; an ack here must be ignored
    mem_ack = 1'b1;
    #1;
    chk({tag, "_done"},       64'(done),     64'(oh));
    chk({tag, "_error"},      64'(error),    64'(exp_err));
    chk({tag, "_end_grant"},  64'(grant),    64'(0));
    chk({tag, "_end_memreq"}, 64'(mem_req),  64'(0));
    chk({tag, "_end_beat"},   64'(beat_idx), 64'(0));
    chk({tag, "_end_rvalid"}, 64'(rvalid),   64'(0));
    chk({tag, "_end_wready"}, 64'(wready),   64'(0));
    if (period > 0 && noack_from < 0)
      chk({tag, "_xfer_cycles"}, 64'(cyc), 64'(LW * period));
    if (!keep_req) req = 2'b00;
    step();
    #1;
    chk({tag, "_idle_done"},   64'(done),    64'(0));
    chk({tag, "_idle_error"},  64'(error),   64'(0));
    chk({tag, "_idle_grant"},  64'(grant),   64'(0));
    chk({tag, "_idle_memreq"}, 64'(mem_req), 64'(0));
    chk({tag, "_idle_rvalid"}, 64'(rvalid),  64'(0));
    mem_ack = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1; req = 2'b00; we1 = 1'b0; addr0 = '0; addr1 = '0;
    wdata1 = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) step();
    check_quiet("reset");
    rst = 1'b0;
    step();

    // port-0 read, unaligned line address, ack every cycle
    addr0 = 32'h0000_1004; req = 2'b01;
    w = pick(req); rr_pref = 1 - w;
    run_burst("p0_read", w, 1, -1, -1, -1, 1'b0);

    // both request together from reset: 0, 1, 0, 1
    rst = 1'b1; step(); rst = 1'b0; rr_pref = 0; step();
    addr0 = 32'h0000_4040; addr1 = 32'h0000_8088; we1 = 1'b0; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w = pick(req); rr_pref = 1 - w;
      chk("rr_order", 64'(w), 64'(i % 2));
      run_burst("rr", w, 1, -1, -1, -1, i != 3);
    end

    // port-1 writeback, ack every 3rd cycle
    we1 = 1'b1; addr1 = 32'h0000_2000; req = 2'b10;
    w = pick(req); rr_pref = 1 - w;
    run_burst("p1_wb", w, 3, -1, -1, -1, 1'b0);

    // no ack after beat 2: timeout exit
    we1 = 1'b0; addr0 = 32'h0001_2340; req = 2'b01;
    w = pick(req); rr_pref = 1 - w;
    run_burst("timeout", w, 1, 2, -1, -1, 1'b0);

    // reset at beat 5, then a port-1 request right after
    addr0 = 32'h0003_0000; req = 2'b01;
    w = pick(req); rr_pref = 1 - w;
    run_burst("rst_mid", w, 1, -1, -1, 5, 1'b0);
    addr1 = 32'h0005_5554; req = 2'b10;
    w = pick(req); rr_pref = 1 - w;
    run_burst("post_rst", w, 1, -1, -1, -1, 1'b0);

    // req[0] dropped at beat 3 while port 1 waits
    addr0 = 32'h0000_7000; addr1 = 32'h0000_9000; req = 2'b11; rr_pref = 0;
    rst = 1'b1; step(); rst = 1'b0; step();
    w = pick(req); rr_pref = 1 - w;
    run_burst("drop_req", w, 1, -1, 3, -1, 1'b1);
    chk("drop_req_left", 64'(req), 64'(2'b10));
    w = pick(req); rr_pref = 1 - w;
    chk("drop_req_next", 64'(w), 64'(1));
    run_burst("drop_next", w, 1, -1, -1, -1, 1'b0);

    // randomized bursts
    for (int i = 0; i < 10; i++) begin
      if (!req[0]) addr0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : 32'($urandom);
      if (!req[1]) begin
        addr1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE8 : 32'($urandom);
        we1   = 1'($urandom_range(0, 1));
      end
      req = req | 2'($urandom_range(1, 3));
      w = pick(req); rr_pref = 1 - w;
      run_burst("rand", w, $urandom_range(0, 2), -1, -1, -1,
                (i != 9) && ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
